// File: rtl/cart_mapper_pkg.sv
// cart_mapper_pkg: FSM state type and default constants shared by the mapper files
package cart_mapper_pkg;
  typedef enum logic [1:0] {ST_SEQ, ST_STREAM, ST_OPEN} state_t;
  localparam logic [15:0] DEF_UNLOCK_SEQ = {8'hA5, 8'h5A};
  localparam logic [17:0] DEF_SO_PATTERN = 18'h0A280;
  localparam logic [7:0] DEF_BANK_BASE = 8'hC0;
  localparam logic [7:0] DEF_RELOCK_ADDR = 8'hFF;
endpackage

// File: rtl/cart_mapper_serializer.sv
// cart_mapper_serializer: loads the pattern, shifts it out LSB first with 1-fill, flags the last bit
module cart_mapper_serializer #(
  parameter logic [63:0] PATTERN = '0,
  parameter int LEN = 18
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic run,
  output logic so,
  output logic done
);
  localparam int CW = $clog2(LEN + 1);
  logic [LEN-1:0] sr;
  logic [CW-1:0] cnt;
  assign so = sr[0];
  assign done = run && cnt == CW'(LEN - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr <= '1;
      cnt <= '0;
    end else if (load) begin
      sr <= PATTERN[LEN-1:0];
      cnt <= '0;
    end else if (run) begin
      sr <= (sr >> 1) | (LEN'(1) << (LEN - 1));
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/cart_mapper.sv
// cart_mapper: address-sequence unlock, serial preamble, then a small bank register file
module cart_mapper
  import cart_mapper_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NUM_BANKS = 4,
  parameter logic [ADDR_W-1:0] BANK_BASE = ADDR_W'(DEF_BANK_BASE),
  parameter logic [8*ADDR_W-1:0] UNLOCK_SEQ = (8*ADDR_W)'(DEF_UNLOCK_SEQ),
  parameter int UNLOCK_LEN = 2,
  parameter logic [63:0] SO_PATTERN = 64'(DEF_SO_PATTERN),
  parameter int SO_LEN = 18,
  parameter bit STRICT = 1'b0,
  parameter logic [ADDR_W-1:0] RELOCK_ADDR = ADDR_W'(DEF_RELOCK_ADDR)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CEn,
  input  logic                        SSn,
  input  logic                        OEn,
  input  logic                        WEn,
  input  logic [ADDR_W-1:0]           ADDR,
  input  logic [DATA_W-1:0]           DQ_I,
  output logic [DATA_W-1:0]           DQ_O,
  output logic                        DQ_OE,
  output logic                        SO,
  output logic                        SO_OE,
  output logic                        UNLOCKED,
  output logic [NUM_BANKS*DATA_W-1:0] BANKS
);
  localparam int IW = $clog2(NUM_BANKS);
  state_t state, state_n;
  logic [2:0] k, k_n;
  logic [DATA_W-1:0] bank [NUM_BANKS];
  logic [ADDR_W:0] off;
  logic sel, in_rng, strobe, rd, wr, open, stream, hit, last, load, done, relock, so_raw;
  assign sel = ~(CEn & SSn);
  assign off = {1'b0, ADDR} - {1'b0, BANK_BASE};
  assign in_rng = off < (ADDR_W+1)'(NUM_BANKS);
  assign strobe = sel & OEn & ~WEn;
  assign rd = sel & in_rng & ~OEn & WEn;
  assign wr = strobe & in_rng;
  assign open = state == ST_OPEN;
  assign stream = state == ST_STREAM;
  assign hit = state == ST_SEQ && ADDR == UNLOCK_SEQ[int'(k)*ADDR_W +: ADDR_W];
  assign last = k == 3'(UNLOCK_LEN - 1);
  assign load = hit & last;
  // a bank write at the relock address wins over relocking
  assign relock = open & strobe & ADDR == RELOCK_ADDR & ~in_rng;
  always_comb begin
    state_n = state == ST_SEQ ? (load ? ST_STREAM : ST_SEQ)
            : state == ST_STREAM ? (done ? ST_OPEN : ST_STREAM)
            : (relock ? ST_SEQ : ST_OPEN);
    k_n = state != ST_SEQ || load ? 3'd0
        : hit ? k + 3'd1
        : ADDR == UNLOCK_SEQ[ADDR_W-1:0] ? 3'd1
        : STRICT ? 3'd0 : k;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_SEQ;
      k <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_BANKS; i++) bank[i] <= '1;
    end else if (open && wr) begin
      bank[off[IW-1:0]] <= DQ_I;
    end
  end
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign BANKS[i*DATA_W +: DATA_W] = bank[i];
  end
  cart_mapper_serializer #(.PATTERN(SO_PATTERN), .LEN(SO_LEN)) u_ser (
    .CLK(CLK), .RST(RST), .load(load), .run(stream), .so(so_raw), .done(done)
  );
  assign DQ_OE = ~RST & open & rd;
  assign DQ_O = DQ_OE ? bank[off[IW-1:0]] : '0;
  assign UNLOCKED = ~RST & open;
  assign SO_OE = ~RST;
  assign SO = RST | so_raw;
endmodule

// File: tb/tb_cart_mapper.sv
// tb_cart_mapper: three mapper variants (default, STRICT, relock inside bank range) against a reference model
module tb_cart_mapper;
  logic clk = 1'b0;
  logic rst = 1'b1, cen = 1'b1, ssn = 1'b1, oen = 1'b1, wen = 1'b1;
  logic [7:0] addr = 8'h00, din = 8'h00;
  logic [2:0] so_w, soe_w, unl_w, dqoe_w;
  logic [2:0][7:0] dqo_w;
  logic [2:0][31:0] banks_w;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cart_mapper #(.STRICT(g == 1), .RELOCK_ADDR(g == 2 ? 8'hC3 : 8'hFF)) u_dut (
      .CLK(clk), .RST(rst), .CEn(cen), .SSn(ssn), .OEn(oen), .WEn(wen),
      .ADDR(addr), .DQ_I(din), .DQ_O(dqo_w[g]), .DQ_OE(dqoe_w[g]), .SO(so_w[g]),
      .SO_OE(soe_w[g]), .UNLOCKED(unl_w[g]), .BANKS(banks_w[g])
    );
  end

  // reference model: unlock progress, stream position (-1 = idle), open flag, bank contents
  logic [17:0] pat = 18'h0A280;
  logic [7:0] seq_t [2] = '{8'h5A, 8'hA5};
  logic [7:0] relock_t [3] = '{8'hFF, 8'hFF, 8'hC3};
  bit strict_t [3] = '{1'b0, 1'b1, 1'b0};
  int mk [3], mpos [3];
  bit mopen [3];
  logic [7:0] mbank [3][4];

  function automatic bit in_bank();
    return addr >= 8'hC0 && addr < 8'hC4;
  endfunction

  function automatic void model_step(int d);
    bit wstb = (!cen || !ssn) && oen && !wen;
    if (rst) begin
      mk[d] = 0; mpos[d] = -1; mopen[d] = 0;
      for (int b = 0; b < 4; b++) mbank[d][b] = 8'hFF;
    end else if (mopen[d]) begin
      if (wstb && in_bank()) mbank[d][addr - 8'hC0] = din;
      else if (wstb && addr == relock_t[d]) begin mopen[d] = 0; mk[d] = 0; end
    end else if (mpos[d] >= 0) begin
      mpos[d]++;
      if (mpos[d] == 18) begin mpos[d] = -1; mopen[d] = 1; end
    end else if (addr == seq_t[mk[d]]) begin
      if (mk[d] == 1) begin mk[d] = 0; mpos[d] = 0; end else mk[d] = 1;
    end else if (addr == seq_t[0]) mk[d] = 1;
    else if (strict_t[d]) mk[d] = 0;
  endfunction

  function automatic logic [2:0] e_so();
    logic [2:0] e;
    for (int d = 0; d < 3; d++) e[d] = rst ? 1'b1 : mpos[d] >= 0 ? pat[mpos[d]] : 1'b1;
    return e;
  endfunction

  function automatic logic [2:0] e_unl();
    logic [2:0] e;
    for (int d = 0; d < 3; d++) e[d] = !rst && mopen[d];
    return e;
  endfunction

  function automatic logic [2:0] e_dqoe();
    logic [2:0] e;
    for (int d = 0; d < 3; d++) e[d] = !rst && mopen[d] && (!cen || !ssn) && !oen && wen && in_bank();
    return e;
  endfunction

  function automatic logic [2:0][7:0] e_dqo();
    logic [2:0][7:0] e;
    logic [2:0] oe = e_dqoe();
    for (int d = 0; d < 3; d++) e[d] = oe[d] ? mbank[d][addr - 8'hC0] : 8'h00;
    return e;
  endfunction

  function automatic logic [2:0][31:0] e_banks();
    logic [2:0][31:0] e;
    for (int d = 0; d < 3; d++) e[d] = {mbank[d][3], mbank[d][2], mbank[d][1], mbank[d][0]};
    return e;
  endfunction

  task automatic drive(bit c, bit s, bit o, bit w, logic [7:0] a, logic [7:0] dd);
    cen = c; ssn = s; oen = o; wen = w; addr = a; din = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; drive(0, 1, 0, 1, 8'hC0, 8'h00); tick();
    n_checks++; if (so_w !== 3'b111) begin n_fail++; $display("FAIL reset_so: got %b want 111", so_w); end
    n_checks++; if (soe_w !== 3'b000) begin n_fail++; $display("FAIL reset_so_oe: got %b want 000", soe_w); end
    n_checks++; if (unl_w !== 3'b000) begin n_fail++; $display("FAIL reset_unlocked: got %b want 000", unl_w); end
    n_checks++; if (dqoe_w !== 3'b000) begin n_fail++; $display("FAIL reset_dq_oe: got %b want 000", dqoe_w); end
    n_checks++; if (banks_w !== {3{32'hFFFFFFFF}}) begin n_fail++; $display("FAIL reset_banks: got %h want all FF", banks_w); end
    rst = 0; #1;
    n_checks++; if (soe_w !== 3'b111) begin n_fail++; $display("FAIL post_reset_so_oe: got %b want 111", soe_w); end
  endtask

  task automatic test_unlock_stream();
    bit exp_bits [18] = '{0,0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0};
    drive(0, 1, 1, 0, 8'hC1, 8'h3C); tick();
    drive(0, 1, 0, 1, 8'hC1, 8'h00); #1;
    n_checks++; if (dqoe_w !== 3'b000) begin n_fail++; $display("FAIL locked_read_oe: got %b want 000", dqoe_w); end
    n_checks++; if (banks_w !== {3{32'hFFFFFFFF}}) begin n_fail++; $display("FAIL locked_write_banks: got %h want all FF", banks_w); end
    tick();
    drive(1, 1, 1, 1, 8'h5A, 8'h00); tick();
    drive(1, 1, 1, 1, 8'hA5, 8'h00); tick();
    drive(1, 1, 1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 18; i++) begin
      n_checks++;
      if (so_w !== {3{exp_bits[i]}} || unl_w !== 3'b000) begin
        n_fail++; $display("FAIL stream_bit%0d: got so=%b unl=%b want so=%b unl=000", i, so_w, unl_w, {3{exp_bits[i]}});
      end
      tick();
    end
    n_checks++; if (unl_w !== 3'b111) begin n_fail++; $display("FAIL unlocked_after_stream: got %b want 111", unl_w); end
    n_checks++; if (so_w !== 3'b111) begin n_fail++; $display("FAIL so_idle_open: got %b want 111", so_w); end
  endtask

  task automatic test_bank_rw();
    drive(0, 1, 1, 0, 8'hC1, 8'h3C); tick();
    n_checks++; if (banks_w !== {3{32'hFFFF3CFF}}) begin n_fail++; $display("FAIL write_c1_banks: got %h want FFFF3CFF x3", banks_w); end
    drive(0, 1, 0, 1, 8'hC1, 8'h00); #1;
    n_checks++; if (dqoe_w !== 3'b111) begin n_fail++; $display("FAIL read_c1_oe: got %b want 111", dqoe_w); end
    n_checks++; if (dqo_w !== {3{8'h3C}}) begin n_fail++; $display("FAIL read_c1_data: got %h want 3C x3", dqo_w); end
    tick();
    drive(1, 0, 1, 0, 8'hC3, 8'h77); tick();
    n_checks++; if (banks_w !== {3{32'h77FF3CFF}}) begin n_fail++; $display("FAIL ss_write_c3: got %h want 77FF3CFF x3", banks_w); end
    n_checks++; if (unl_w !== 3'b111) begin n_fail++; $display("FAIL bank_over_relock: got %b want 111", unl_w); end
    drive(0, 1, 0, 0, 8'hC0, 8'h11); #1;
    n_checks++; if (dqoe_w !== 3'b000) begin n_fail++; $display("FAIL oe_we_both_read: got %b want 000", dqoe_w); end
    tick();
    drive(1, 1, 1, 0, 8'hC0, 8'h22); tick();
    n_checks++; if (banks_w !== {3{32'h77FF3CFF}}) begin n_fail++; $display("FAIL no_write_leak: got %h want 77FF3CFF x3", banks_w); end
  endtask

  task automatic test_relock();
    drive(0, 1, 1, 0, 8'hFF, 8'h99); tick();
    n_checks++; if (unl_w !== 3'b100) begin n_fail++; $display("FAIL relock_unlocked: got %b want 100", unl_w); end
    drive(0, 1, 0, 1, 8'hC0, 8'h00); #1;
    n_checks++; if (dqoe_w !== 3'b100) begin n_fail++; $display("FAIL relock_read_oe: got %b want 100", dqoe_w); end
    n_checks++; if (dqo_w !== {8'hFF, 8'h00, 8'h00}) begin n_fail++; $display("FAIL relock_read_data: got %h want FF0000", dqo_w); end
    n_checks++; if (banks_w !== {3{32'h77FF3CFF}}) begin n_fail++; $display("FAIL relock_banks: got %h want 77FF3CFF x3", banks_w); end
    tick();
  endtask

  task automatic test_strict();
    logic [7:0] a1 [4] = '{8'h5A, 8'h00, 8'h00, 8'hA5};
    rst = 1; drive(1, 1, 1, 1, 8'h00, 8'h00); tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin drive(1, 1, 1, 1, a1[i], 8'h00); tick(); end
    drive(1, 1, 1, 1, 8'h00, 8'h00);
    n_checks++; if (so_w !== 3'b010) begin n_fail++; $display("FAIL strict_gap_so: got %b want 010", so_w); end
    for (int i = 0; i < 18; i++) tick();
    n_checks++; if (unl_w !== 3'b101) begin n_fail++; $display("FAIL strict_gap_unl: got %b want 101", unl_w); end
    drive(1, 1, 1, 1, 8'h5A, 8'h00); tick();
    drive(1, 1, 1, 1, 8'hA5, 8'h00); tick();
    drive(1, 1, 1, 1, 8'h00, 8'h00);
    n_checks++; if (so_w !== 3'b101) begin n_fail++; $display("FAIL strict_retry_so: got %b want 101", so_w); end
    for (int i = 0; i < 18; i++) tick();
    n_checks++; if (unl_w !== 3'b111) begin n_fail++; $display("FAIL strict_retry_unl: got %b want 111", unl_w); end
  endtask

  task automatic test_midstream_reset();
    drive(0, 1, 1, 0, 8'hC2, 8'h55); tick();
    rst = 1; drive(1, 1, 1, 1, 8'h00, 8'h00); tick(); rst = 0;
    n_checks++; if (banks_w !== {3{32'hFFFFFFFF}}) begin n_fail++; $display("FAIL reset_clears_banks: got %h want all FF", banks_w); end
    drive(1, 1, 1, 1, 8'h5A, 8'h00); tick();
    drive(1, 1, 1, 1, 8'hA5, 8'h00); tick();
    drive(1, 1, 1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 9; i++) tick();
    rst = 1; #1;
    n_checks++; if (so_w !== 3'b111 || soe_w !== 3'b000) begin n_fail++; $display("FAIL during_reset: got so=%b so_oe=%b want 111/000", so_w, soe_w); end
    tick();
    n_checks++; if (so_w !== 3'b111 || soe_w !== 3'b000 || unl_w !== 3'b000) begin
      n_fail++; $display("FAIL midstream_reset: got so=%b so_oe=%b unl=%b want 111/000/000", so_w, soe_w, unl_w);
    end
    n_checks++; if (banks_w !== {3{32'hFFFFFFFF}}) begin n_fail++; $display("FAIL midstream_banks: got %h want all FF", banks_w); end
    rst = 0; drive(1, 1, 1, 1, 8'hA5, 8'h00); tick();
    drive(1, 1, 1, 1, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (so_w !== 3'b111 || unl_w !== 3'b000) begin
        n_fail++; $display("FAIL aborted_stream_%0d: got so=%b unl=%b want 111/000", i, so_w, unl_w);
      end
      tick();
    end
  endtask

  task automatic test_random();
    rst = 1; drive(1, 1, 1, 1, 8'h00, 8'h00); tick(); rst = 0;
    for (int i = 0; i < 700; i++) begin
      int s = $urandom_range(0, 7);
      logic [7:0] a;
      a = s == 0 ? 8'h5A : s == 1 ? 8'hA5 : s == 5 ? 8'hFF : s == 6 ? 8'hC3
        : s == 7 ? 8'($urandom) : 8'hC0 + 8'($urandom_range(0, 3));
      rst = $urandom_range(0, 199) == 0;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), a, 8'($urandom));
      #1;
      n_checks++; if (so_w !== e_so()) begin n_fail++; $display("FAIL rnd_so cyc %0d: got %b want %b", i, so_w, e_so()); end
      n_checks++; if (soe_w !== {3{!rst}}) begin n_fail++; $display("FAIL rnd_so_oe cyc %0d: got %b want %b", i, soe_w, {3{!rst}}); end
      n_checks++; if (unl_w !== e_unl()) begin n_fail++; $display("FAIL rnd_unlocked cyc %0d: got %b want %b", i, unl_w, e_unl()); end
      n_checks++; if (dqoe_w !== e_dqoe()) begin n_fail++; $display("FAIL rnd_dq_oe cyc %0d: got %b want %b", i, dqoe_w, e_dqoe()); end
      n_checks++; if (dqo_w !== e_dqo()) begin n_fail++; $display("FAIL rnd_dq_o cyc %0d: got %h want %h", i, dqo_w, e_dqo()); end
      n_checks++; if (banks_w !== e_banks()) begin n_fail++; $display("FAIL rnd_banks cyc %0d: got %h want %h", i, banks_w, e_banks()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_unlock_stream();
    test_bank_rw();
    test_relock();
    test_strict();
    test_midstream_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
